serial_vector_adder: RTL
========================

SERIAL_VECTOR_ADDER -- requirements
Module: serial_vector_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand/sum width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 operand_a  input  WIDTH  first addend.
REQ-007 operand_b  input  WIDTH  second addend.
REQ-008 carry_in  input  1  carry into bit 0.
REQ-009 out_valid  output  1  result held on sum/carry_out.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  WIDTH  operand_a + operand_b + carry_in, modulo 2^WIDTH.
REQ-012 carry_out  output  1  carry out of bit WIDTH-1.
REQ-013 busy  output  1  high in SHIFT or DONE.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; encoding from the shared package.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid & in_ready, load operand_a/operand_b into shift registers, carry_in into carry flop, clear bit counter, go to SHIFT.
REQ-017 SHIFT: each cycle, the one-bit full-adder stage adds A[0], B[0], carry flop; A/B shift right by one; sum bit enters result register at MSB, result shifts right; carry flop takes stage carry; counter +1.
REQ-018 SHIFT SHALL last exactly WIDTH cycles; on the edge where counter = WIDTH-1, go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH+1 rising edges after (and counting) the accept edge.
REQ-020 DONE: sum and carry_out SHALL hold stable until out_valid & out_ready; that edge returns to IDLE.
REQ-021 out_ready low SHALL stall DONE indefinitely with no output change.
REQ-022 in_valid during SHIFT/DONE SHALL be ignored; operand inputs need not stay stable after acceptance.
REQ-023 Throughput: at most one operation per WIDTH+2 cycles; no overlap of accept and result handshake.
REQ-024 sum/carry_out SHALL be 0 outside DONE.
REQ-025 Counter width SHALL be $clog2(WIDTH); no wrap during SHIFT.

Reset
REQ-026 rst high at any edge, any state (including mid-SHIFT or stalled DONE), SHALL force IDLE, clear shift/result registers, carry flop, counter; the in-flight operation is discarded.
REQ-027 Output values during/after reset: in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0.
REQ-028 in_valid coincident with rst SHALL not be accepted.

Structure
REQ-029 Shared package vedic_adder_pkg SHALL hold the FSM state enum and the default-width constant (32).
REQ-030 The per-bit addition SHALL instantiate the existing full_adder (one instance); no other sub-modules.
REQ-031 Datapath registers: A shift, B shift, result shift (each WIDTH), carry flop, counter, state.

Verification
REQ-032 WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, carry_out=1, out_valid 33 edges after accept.
REQ-033 a=0x12345678, b=0x9ABCDEF0, cin=1 -> sum=0xACF13569, carry_out=0.
REQ-034 Backpressure: out_ready low 5 cycles in DONE -> sum/out_valid stable 5 cycles, IDLE one edge after out_ready=1.
REQ-035 rst pulse at SHIFT bit 10 -> next cycle in_ready=1, out_valid=0, sum=0; new op a=3,b=4,cin=0 -> sum=7.
REQ-036 in_valid held high across two ops with changing operands during SHIFT -> only first operand set used; second accepted only after IDLE.
REQ-037 WIDTH=8, 1000 random ops vs. reference model a+b+cin -> zero mismatches, all latencies = 9 edges.

Source files
------------

// File: rtl/vedic_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vedic_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder stage used by the serial adder datapath.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_vector_adder.sv
// Bit-serial adder: sum = operand_a + operand_b + carry_in, one bit per cycle, LSB first.
// Latency: out_valid rises WIDTH+1 edges after (and counting) the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no overlap.
module serial_vector_adder
  import vedic_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   res_sh;
  logic               carry_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   res_next;

  // The single adder stage always looks at the current LSBs and the running carry.
  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_carry)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at position 0.
  assign res_next = {fa_sum, res_sh[WIDTH-1:1]};

  // Control FSM plus datapath; handshake and result outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_q   <= 1'b0;
      bit_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= operand_a;
            b_sh     <= operand_b;
            carry_q  <= carry_in;
            res_sh   <= '0;
            bit_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_next;
          carry_q <= fa_carry;
          if (bit_cnt == LAST_BIT) begin
            // Last bit: counter parks at zero rather than stepping past WIDTH-1.
            bit_cnt   <= '0;
            sum       <= res_next;
            carry_out <= fa_carry;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            sum       <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          sum       <= '0;
          carry_out <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
